// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with configurable wait states
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wd,
    input  logic        m_flush,
    output logic [31:0] m_rd,
    output logic        m_stall,
    output logic        m_done,
    output logic        m_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wd_q;
    logic            we_q;
    logic            mis_q;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            addr_mis;
    logic [AW-1:0]   rd_idx;
    logic            rd_mis;
    logic            commit;

    // Address bits above the array index wrap modulo DEPTH.
    logic            unused_addr;
    assign unused_addr = ^m_addr[31:AW+2];

    assign addr_mis = (m_addr[1:0] != 2'b00);
    assign accept   = (state == S_IDLE) && m_req && !m_flush;

    // The read edge of a fresh access (zero wait states or misaligned) uses the live
    // address because the latched copy is only captured on that same edge.
    assign rd_idx = (state == S_IDLE) ? m_addr[AW+1:2] : idx_q;
    assign rd_mis = (state == S_IDLE) ? addr_mis : mis_q;

    // Stores commit on the edge leaving the response cycle unless flushed.
    assign commit = (state == S_RESP) && we_q && !mis_q && !m_flush;

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        m_stall   = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        case (state)
            S_IDLE: begin
                m_stall = rst_n && m_req && !m_flush;
                if (accept) begin
                    state_nxt = (WAIT_STATES == 0 || addr_mis) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                m_stall = 1'b1;
                if (m_flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                m_done    = 1'b1;
                m_err     = mis_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, request latches, wait counter and read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            idx_q <= '0;
            wd_q  <= 32'd0;
            we_q  <= 1'b0;
            mis_q <= 1'b0;
            m_rd  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_q <= m_addr[AW+1:2];
                wd_q  <= m_wd;
                we_q  <= m_we;
                mis_q <= addr_mis;
                cnt   <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state_nxt == S_RESP && state != S_RESP) begin
                if (rd_mis) begin
                    m_rd <= 32'd0;
                end else if (!((state == S_IDLE) ? m_we : we_q)) begin
                    m_rd <= mem[rd_idx];
                end
            end
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_q] <= wd_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req2 = 0, we2 = 0, flush2 = 0;
    logic [31:0] addr2 = 0, wd2 = 0;
    logic [31:0] rd2;
    logic        stall2, done2, err2;

    logic        req0 = 0, we0 = 0, flush0 = 0;
    logic [31:0] addr0 = 0, wd0 = 0;
    logic [31:0] rd0;
    logic        stall0, done0, err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst_n(rst_n), .m_req(req2), .m_we(we2), .m_addr(addr2),
        .m_wd(wd2), .m_flush(flush2), .m_rd(rd2), .m_stall(stall2),
        .m_done(done2), .m_err(err2)
    );

    dmem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .m_req(req0), .m_we(we0), .m_addr(addr0),
        .m_wd(wd0), .m_flush(flush0), .m_rd(rd0), .m_stall(stall0),
        .m_done(done0), .m_err(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd, input logic flush);
        if (sel == 2) begin
            req2 = req; we2 = we; addr2 = addr; wd2 = wd; flush2 = flush;
        end else begin
            req0 = req; we0 = we; addr0 = addr; wd0 = wd; flush0 = flush;
        end
    endtask

    // {rd, stall, done, err}
    function automatic logic [34:0] obs(input int sel);
        return (sel == 2) ? {rd2, stall2, done2, err2} : {rd0, stall0, done0, err0};
    endfunction

    // Full access without flush; lat is the response cycle index.
    task automatic access(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat, input logic [31:0] exp_rd,
                          input logic exp_err, input string tag);
        logic [34:0] o;
        @(posedge clk); #1;
        drive(sel, 1'b1, we, addr, wd, 1'b0);
        #1 o = obs(sel);
        check({tag, " stall c0"}, 32'(o[2]), 32'd1);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #2;
            o = obs(sel);
            if (c < lat) begin
                check({tag, " stall wait"}, 32'(o[2]), 32'd1);
                check({tag, " done wait"}, 32'(o[1]), 32'd0);
            end else begin
                check({tag, " stall resp"}, 32'(o[2]), 32'd0);
                check({tag, " done resp"}, 32'(o[1]), 32'd1);
                check({tag, " err resp"}, 32'(o[0]), 32'(exp_err));
                if (!we) check({tag, " rd"}, o[34:3], exp_rd);
            end
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1 o = obs(sel);
        check({tag, " done after"}, 32'(o[1]), 32'd0);
        check({tag, " stall after"}, 32'(o[2]), 32'd0);
        if (!we) check({tag, " rd held"}, o[34:3], exp_rd);
    endtask

    // Store on the 2-wait-state instance with flush raised from cycle fc onward.
    task automatic flushed_store(input logic [31:0] addr, input logic [31:0] wd,
                                 input int fc, input logic [31:0] exp_rd, input string tag);
        logic [34:0] o;
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b1, addr, wd, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c >= fc) flush2 = 1'b1;
            #1 o = obs(2);
            check({tag, " stall"}, 32'(o[2]), 32'((c <= fc) && (c < 3)));
            check({tag, " done"}, 32'(o[1]), 32'((fc == 3) && (c == 3)));
        end
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1 o = obs(2);
        check({tag, " done after"}, 32'(o[1]), 32'd0);
        check({tag, " rd unchanged"}, o[34:3], exp_rd);
    endtask

    initial begin
        logic [34:0] o;
        // Reset state
        #2;
        check("reset rd2", rd2, 32'd0);
        check("reset stall2", 32'(stall2), 32'd0);
        check("reset done2", 32'(done2), 32'd0);
        check("reset err2", 32'(err2), 32'd0);
        check("reset rd0", rd0, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Two wait states: store then load
        access(2, 1'b1, 32'h10, 32'hDEADBEEF, 3, 32'd0, 1'b0, "ws2 st10");
        access(2, 1'b0, 32'h10, 32'd0, 3, 32'hDEADBEEF, 1'b0, "ws2 ld10");

        // Zero wait states, top word and address aliasing
        access(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1, 32'd0, 1'b0, "ws0 st3fc");
        access(0, 1'b0, 32'h3FC, 32'd0, 1, 32'hCAFEF00D, 1'b0, "ws0 ld3fc");
        access(0, 1'b1, 32'h000, 32'h11111111, 1, 32'd0, 1'b0, "ws0 st0");
        access(0, 1'b0, 32'h400, 32'd0, 1, 32'h11111111, 1'b0, "ws0 ld400");

        // Misaligned accesses
        access(0, 1'b1, 32'h10, 32'h55AA55AA, 1, 32'd0, 1'b0, "ws0 st10");
        access(0, 1'b0, 32'h13, 32'd0, 1, 32'd0, 1'b1, "ws0 mis ld13");
        access(0, 1'b1, 32'h11, 32'hFFFFFFFF, 1, 32'd0, 1'b1, "ws0 mis st11");
        access(0, 1'b0, 32'h10, 32'd0, 1, 32'h55AA55AA, 1'b0, "ws0 ld10 after mis");

        // Flush in WAIT, on the last wait cycle, and in RESP
        access(2, 1'b1, 32'h20, 32'hAAAA0000, 3, 32'd0, 1'b0, "ws2 st20 old");
        flushed_store(32'h20, 32'h12345678, 1, 32'hDEADBEEF, "flush wait");
        flushed_store(32'h20, 32'h12345678, 2, 32'hDEADBEEF, "flush cnt1");
        flushed_store(32'h20, 32'h12345678, 3, 32'hDEADBEEF, "flush resp");
        access(2, 1'b0, 32'h20, 32'd0, 3, 32'hAAAA0000, 1'b0, "ws2 ld20 after flush");

        // Reset in the middle of a store's wait period
        access(2, 1'b1, 32'h30, 32'h0BADF00D, 3, 32'd0, 1'b0, "ws2 st30 old");
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b1, 32'h30, 32'h77777777, 1'b0);
        @(posedge clk); #1;
        req2 = 1'b0;
        rst_n = 1'b0;
        #1 o = obs(2);
        check("rst mid rd", o[34:3], 32'd0);
        check("rst mid stall", 32'(o[2]), 32'd0);
        check("rst mid done", 32'(o[1]), 32'd0);
        check("rst mid err", 32'(o[0]), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        access(2, 1'b0, 32'h30, 32'd0, 3, 32'h0BADF00D, 1'b0, "ws2 ld30 after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
